asrv32_csr_unit: RTL and testbench

Parametrised successor to the machine-mode CSR/trap block. It holds the M-mode CSR file, prioritises exceptions and interrupts, and drives trap entry and MRET through a registered sequencer. It adds vectored mtvec, 0-16 fast local interrupts, an internal microsecond mtime with mtimecmp, and mcountinhibit-gated 64-bit counters. It sits beside the MEMORYACCESS stage and feeds the PC-select logic.

---
 rtl/asrv32_csr_unit.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_asrv32_csr_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/asrv32_csr_unit.sv
// M-mode CSR file, exception/interrupt prioritiser, mtime/mtimecmp, counters and a registered trap/MRET sequencer.
// Old CSR value and trap/MRET pulses appear 1 cycle after i_csr_stage_en; no backpressure, stage_en is ignored while a pulse is out.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif

module asrv32_csr_unit #(
    parameter int          CLK_FREQ_MHZ = 100,
    parameter logic [31:0] TRAP_ADDRESS = 32'h0000_0000,
    parameter int          NUM_FAST_IRQ = 4,
    parameter bit          VECTORED_EN  = 1'b1,
    parameter logic [31:0] HART_ID      = 32'h0000_0000
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst_n,
    input  logic                                         i_csr_stage_en,
    input  logic                                         i_external_interrupt,
    input  logic                                         i_software_interrupt,
    input  logic [(NUM_FAST_IRQ > 0 ? NUM_FAST_IRQ : 1)-1:0] i_fast_irq,
    input  logic                                         i_mtimecmp_wr_en,
    input  logic [63:0]                                  i_mtimecmp_din,
    output logic [63:0]                                  o_mtime,
    input  logic                                         i_is_inst_illegal,
    input  logic                                         i_is_ecall,
    input  logic                                         i_is_ebreak,
    input  logic                                         i_is_mret,
    input  logic [`OPCODE_WIDTH-1:0]                     i_opcode,
    input  logic [2:0]                                   i_funct3,
    input  logic [11:0]                                  i_csr_index,
    input  logic [31:0]                                  i_imm,
    input  logic [31:0]                                  i_rs1,
    input  logic [31:0]                                  i_alu_result,
    input  logic [31:0]                                  i_pc,
    input  logic                                         i_minstret_inc,
    output logic [31:0]                                  o_csr_out,
    output logic [31:0]                                  o_return_address,
    output logic [31:0]                                  o_trap_address,
    output logic                                         o_go_to_trap_q,
    output logic                                         o_return_from_trap_q
);

    // One-hot opcode bit order: {FENCE, SYSTEM, AUIPC, LUI, JALR, JAL, BRANCH, STORE, LOAD, ITYPE, RTYPE}
    localparam int OP_RTYPE = 0, OP_ITYPE = 1, OP_LOAD = 2, OP_STORE = 3, OP_BRANCH = 4;
    localparam int OP_JAL = 5, OP_JALR = 6, OP_LUI = 7, OP_AUIPC = 8, OP_SYSTEM = 9, OP_FENCE = 10;

    localparam logic [11:0] CSR_MSTATUS = 12'h300, CSR_MIE = 12'h304, CSR_MTVEC = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINH = 12'h320, CSR_MSCRATCH = 12'h340, CSR_MEPC = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342, CSR_MTVAL = 12'h343, CSR_MIP = 12'h344;
    localparam logic [11:0] CSR_MCYCLE = 12'hB00, CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH = 12'hB80, CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_TIME = 12'hC01, CSR_TIMEH = 12'hC81;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11, CSR_MARCHID = 12'hF12;
    localparam logic [11:0] CSR_MIMPID = 12'hF13, CSR_MHARTID = 12'hF14;

    localparam int PW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_TRAP, S_MRET} state_t;

    state_t        state_q, state_d;
    logic          mstatus_mie_q, mstatus_mie_d, mpie_q, mpie_d;
    logic [31:0]   mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0]   mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [2:0]    mcountinh_q, mcountinh_d;
    logic [63:0]   mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic [63:0]   mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   csr_out_q, csr_out_d, trap_addr_q, trap_addr_d;

    logic [31:0] fast_pend, fast_mask, mip, mstatus_r, irq_pend, csr_src, csr_rdata, csr_wdata;
    logic [31:0] exc_tval, trap_target;
    logic [4:0]  exc_cause, irq_cause, trap_cause;
    logic        en, is_csr, csr_wr_req, csr_impl, csr_ro, csr_illegal, csr_wr;
    logic        size_mis, exc_vld, irq_vld, trap_take, mret_take, mtip, tick;
    logic        cyc_inc, ret_inc, cyc_carry, ret_carry;
    logic        unused_opcode_bits;

    assign unused_opcode_bits = ^{i_opcode[OP_FENCE], i_opcode[OP_AUIPC], i_opcode[OP_LUI],
                                  i_opcode[OP_ITYPE], i_opcode[OP_RTYPE]};

    always_comb begin
        fast_pend = '0;
        fast_mask = '0;
        for (int i = 0; i < NUM_FAST_IRQ; i++) begin
            fast_pend[16+i] = i_fast_irq[i];
            fast_mask[16+i] = 1'b1;
        end
    end

    assign mtip      = (mtime_q >= mtimecmp_q);
    assign mstatus_r = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mstatus_mie_q, 3'b0};

    always_comb begin
        mip     = fast_pend;
        mip[11] = i_external_interrupt;
        mip[7]  = mtip;
        mip[3]  = i_software_interrupt;
    end

    assign en         = i_csr_stage_en && (state_q == S_IDLE);
    assign is_csr     = i_opcode[OP_SYSTEM] && (i_funct3[1:0] != 2'b00);
    assign csr_src    = i_funct3[2] ? i_imm : i_rs1;
    assign csr_wr_req = is_csr && ((i_funct3[1:0] == 2'b01) || (csr_src != 32'h0));

    always_comb begin
        csr_rdata = '0;
        csr_impl  = 1'b1;
        csr_ro    = 1'b0;
        case (i_csr_index)
            CSR_MSTATUS:   csr_rdata = mstatus_r;
            CSR_MIE:       csr_rdata = mie_q;
            CSR_MTVEC:     csr_rdata = mtvec_q;
            CSR_MCOUNTINH: csr_rdata = {29'b0, mcountinh_q};
            CSR_MSCRATCH:  csr_rdata = mscratch_q;
            CSR_MEPC:      csr_rdata = mepc_q;
            CSR_MCAUSE:    csr_rdata = mcause_q;
            CSR_MTVAL:     csr_rdata = mtval_q;
            CSR_MIP:       csr_rdata = mip;
            CSR_MCYCLE:    csr_rdata = mcycle_q[31:0];
            CSR_MCYCLEH:   csr_rdata = mcycle_q[63:32];
            CSR_MINSTRET:  csr_rdata = minstret_q[31:0];
            CSR_MINSTRETH: csr_rdata = minstret_q[63:32];
            CSR_TIME:      begin csr_rdata = mtime_q[31:0];  csr_ro = 1'b1; end
            CSR_TIMEH:     begin csr_rdata = mtime_q[63:32]; csr_ro = 1'b1; end
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: csr_ro = 1'b1;
            CSR_MHARTID:   begin csr_rdata = HART_ID; csr_ro = 1'b1; end
            default:       csr_impl = 1'b0;
        endcase
        case (i_funct3[1:0])
            2'b10:   csr_wdata = csr_rdata | csr_src;
            2'b11:   csr_wdata = csr_rdata & ~csr_src;
            default: csr_wdata = csr_src;
        endcase
        // Only the fast bits of mip may be "written", and those just mirror their inputs.
        if (i_csr_index == CSR_MIP) csr_ro = (((csr_wdata ^ mip) & ~fast_mask) != 32'h0);
    end

    assign csr_illegal = is_csr && (!csr_impl || (csr_wr_req && csr_ro));
    assign size_mis    = ((i_funct3[1:0] == 2'b01) && i_alu_result[0]) ||
                         ((i_funct3[1:0] == 2'b10) && (i_alu_result[1:0] != 2'b00));

    always_comb begin
        exc_vld   = 1'b1;
        exc_cause = '0;
        exc_tval  = '0;
        if (i_is_inst_illegal || csr_illegal) exc_cause = 5'd2;
        else if (i_is_ebreak)                 exc_cause = 5'd3;
        else if (i_is_ecall)                  exc_cause = 5'd11;
        else if ((i_opcode[OP_BRANCH] || i_opcode[OP_JAL] || i_opcode[OP_JALR]) &&
                 (i_alu_result[1:0] != 2'b00)) begin
            exc_cause = 5'd0;
            exc_tval  = i_alu_result;
        end else if (i_opcode[OP_LOAD] && size_mis) begin
            exc_cause = 5'd4;
            exc_tval  = i_alu_result;
        end else if (i_opcode[OP_STORE] && size_mis) begin
            exc_cause = 5'd6;
            exc_tval  = i_alu_result;
        end else exc_vld = 1'b0;
    end

    always_comb begin
        irq_pend  = mie_q & mip;
        irq_vld   = mstatus_mie_q && (irq_pend != 32'h0);
        irq_cause = '0;
        for (int i = NUM_FAST_IRQ - 1; i >= 0; i--)
            if (irq_pend[16+i]) irq_cause = 5'(16 + i);
        if (irq_pend[7])  irq_cause = 5'd7;
        if (irq_pend[3])  irq_cause = 5'd3;
        if (irq_pend[11]) irq_cause = 5'd11;
    end

    assign trap_take  = en && (exc_vld || irq_vld);
    assign mret_take  = en && !trap_take && i_is_mret;
    assign csr_wr     = en && csr_wr_req && !trap_take;
    assign trap_cause = exc_vld ? exc_cause : irq_cause;
    assign trap_target = {mtvec_q[31:2], 2'b00} +
                         ((!exc_vld && VECTORED_EN && (mtvec_q[1:0] == 2'b01)) ?
                          {25'b0, trap_cause, 2'b00} : 32'h0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (trap_take) state_d = S_TRAP; else if (mret_take) state_d = S_MRET;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mstatus_mie_d = mstatus_mie_q;
        mpie_d        = mpie_q;
        mie_d         = mie_q;
        mtvec_d       = mtvec_q;
        mscratch_d    = mscratch_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        mtval_d       = mtval_q;
        mcountinh_d   = mcountinh_q;
        if (csr_wr) begin
            case (i_csr_index)
                CSR_MSTATUS:   begin mstatus_mie_d = csr_wdata[3]; mpie_d = csr_wdata[7]; end
                CSR_MIE:       mie_d = csr_wdata & (fast_mask | 32'h0000_0888);
                CSR_MTVEC:     mtvec_d = {csr_wdata[31:2],
                                          (VECTORED_EN && csr_wdata[1:0] == 2'b01) ? 2'b01 : 2'b00};
                CSR_MCOUNTINH: mcountinh_d = {csr_wdata[2], 1'b0, csr_wdata[0]};
                CSR_MSCRATCH:  mscratch_d = csr_wdata;
                CSR_MEPC:      mepc_d = csr_wdata;
                CSR_MCAUSE:    mcause_d = csr_wdata;
                CSR_MTVAL:     mtval_d = csr_wdata;
                default:       ;
            endcase
        end
        if (trap_take) begin
            mepc_d        = i_pc;
            mcause_d      = {!exc_vld, 26'b0, trap_cause};
            mtval_d       = exc_tval;
            mpie_d        = mstatus_mie_q;
            mstatus_mie_d = 1'b0;
        end else if (mret_take) begin
            mstatus_mie_d = mpie_q;
            mpie_d        = 1'b1;
        end
    end

    // A write to a half replaces that half's increment; carries propagate in the same cycle.
    always_comb begin
        cyc_inc   = !mcountinh_q[0];
        ret_inc   = !mcountinh_q[2] && i_minstret_inc;
        cyc_carry = cyc_inc && !(csr_wr && i_csr_index == CSR_MCYCLE) && (&mcycle_q[31:0]);
        ret_carry = ret_inc && !(csr_wr && i_csr_index == CSR_MINSTRET) && (&minstret_q[31:0]);
        mcycle_d[31:0]    = (csr_wr && i_csr_index == CSR_MCYCLE) ? csr_wdata :
                            mcycle_q[31:0] + 32'(cyc_inc);
        mcycle_d[63:32]   = (csr_wr && i_csr_index == CSR_MCYCLEH) ? csr_wdata :
                            mcycle_q[63:32] + 32'(cyc_carry);
        minstret_d[31:0]  = (csr_wr && i_csr_index == CSR_MINSTRET) ? csr_wdata :
                            minstret_q[31:0] + 32'(ret_inc);
        minstret_d[63:32] = (csr_wr && i_csr_index == CSR_MINSTRETH) ? csr_wdata :
                            minstret_q[63:32] + 32'(ret_carry);
    end

    assign tick        = (presc_q == PW'(CLK_FREQ_MHZ - 1));
    assign presc_d     = tick ? '0 : presc_q + PW'(1);
    assign mtime_d     = mtime_q + 64'(tick);
    assign mtimecmp_d  = i_mtimecmp_wr_en ? i_mtimecmp_din : mtimecmp_q;
    assign csr_out_d   = (en && is_csr) ? csr_rdata : csr_out_q;
    assign trap_addr_d = trap_take ? trap_target : trap_addr_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            mstatus_mie_q <= 1'b0;
            mpie_q        <= 1'b0;
            mie_q         <= '0;
            mtvec_q       <= {TRAP_ADDRESS[31:2], 2'b00};
            mscratch_q    <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            mcountinh_q   <= '0;
            mcycle_q      <= '0;
            minstret_q    <= '0;
            mtime_q       <= '0;
            mtimecmp_q    <= '1;
            presc_q       <= '0;
            csr_out_q     <= '0;
            trap_addr_q   <= '0;
        end else begin
            state_q       <= state_d;
            mstatus_mie_q <= mstatus_mie_d;
            mpie_q        <= mpie_d;
            mie_q         <= mie_d;
            mtvec_q       <= mtvec_d;
            mscratch_q    <= mscratch_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mtval_q       <= mtval_d;
            mcountinh_q   <= mcountinh_d;
            mcycle_q      <= mcycle_d;
            minstret_q    <= minstret_d;
            mtime_q       <= mtime_d;
            mtimecmp_q    <= mtimecmp_d;
            presc_q       <= presc_d;
            csr_out_q     <= csr_out_d;
            trap_addr_q   <= trap_addr_d;
        end
    end

    assign o_mtime              = mtime_q;
    assign o_csr_out            = csr_out_q;
    assign o_return_address     = mepc_q;
    assign o_trap_address       = trap_addr_q;
    assign o_go_to_trap_q       = (state_q == S_TRAP);
    assign o_return_from_trap_q = (state_q == S_MRET);

endmodule

// File: tb/tb_asrv32_csr_unit.sv
// Directed bench for asrv32_csr_unit: CSR ops, traps, MRET, counters, mtime and reset behaviour.
module tb_asrv32_csr_unit;

    localparam int OP_RTYPE = 0, OP_LOAD = 2, OP_STORE = 3, OP_JALR = 6, OP_SYSTEM = 9;
    localparam logic [11:0] MSTATUS = 12'h300, MIE = 12'h304, MTVEC = 12'h305, MCOUNTINH = 12'h320;
    localparam logic [11:0] MSCRATCH = 12'h340, MEPC = 12'h341, MCAUSE = 12'h342, MTVAL = 12'h343;
    localparam logic [11:0] MIP = 12'h344, MCYCLE = 12'hB00, MINSTRET = 12'hB02, MCYCLEH = 12'hB80;

    logic        clk = 1'b0;
    logic        rst_n, stage_en, ext_irq, sw_irq, mtimecmp_wr, illegal, ecall, ebreak, mret, minstret_inc;
    logic [3:0]  fast_irq;
    logic [63:0] mtimecmp_din, mtime;
    logic [10:0] opcode;
    logic [2:0]  funct3;
    logic [11:0] csr_index;
    logic [31:0] imm, rs1, alu, pc, csr_out, ret_addr, trap_addr;
    logic        go_trap, ret_trap;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    asrv32_csr_unit #(
        .CLK_FREQ_MHZ(4), .TRAP_ADDRESS(32'h0000_0040), .NUM_FAST_IRQ(4),
        .VECTORED_EN(1'b1), .HART_ID(32'h0000_0007)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_csr_stage_en(stage_en),
        .i_external_interrupt(ext_irq), .i_software_interrupt(sw_irq), .i_fast_irq(fast_irq),
        .i_mtimecmp_wr_en(mtimecmp_wr), .i_mtimecmp_din(mtimecmp_din), .o_mtime(mtime),
        .i_is_inst_illegal(illegal), .i_is_ecall(ecall), .i_is_ebreak(ebreak), .i_is_mret(mret),
        .i_opcode(opcode), .i_funct3(funct3), .i_csr_index(csr_index), .i_imm(imm), .i_rs1(rs1),
        .i_alu_result(alu), .i_pc(pc), .i_minstret_inc(minstret_inc),
        .o_csr_out(csr_out), .o_return_address(ret_addr), .o_trap_address(trap_addr),
        .o_go_to_trap_q(go_trap), .o_return_from_trap_q(ret_trap)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stage_en = 1'b0; opcode = '0; funct3 = '0; imm = '0; rs1 = '0; alu = '0;
        illegal = 1'b0; ecall = 1'b0; ebreak = 1'b0; mret = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clear_inputs();
        ext_irq = 1'b0; sw_irq = 1'b0; fast_irq = '0; mtimecmp_wr = 1'b0; mtimecmp_din = '0;
        minstret_inc = 1'b0; csr_index = '0; pc = '0;
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    task automatic csr_op(input logic [2:0] f3, input logic [11:0] idx,
                          input logic [31:0] rs1_v, input logic [31:0] imm_v);
        clear_inputs();
        opcode[OP_SYSTEM] = 1'b1; funct3 = f3; csr_index = idx; rs1 = rs1_v; imm = imm_v;
        stage_en = 1'b1;
        cyc();
        clear_inputs();
    endtask

    task automatic csr_rd(input logic [11:0] idx);
        csr_op(3'b010, idx, 32'h0, 32'h0);
    endtask

    task automatic issue(input int op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic ec, input logic eb, input logic mr);
        clear_inputs();
        opcode[op] = 1'b1; funct3 = f3; alu = addr; ecall = ec; ebreak = eb; mret = mr;
        stage_en = 1'b1;
        cyc();
        clear_inputs();
    endtask

    initial begin
        do_reset();
        chk("rst_trap", go_trap, 1'b0);
        chk("rst_ret", ret_trap, 1'b0);
        chk("rst_csr_out", csr_out, 32'h0);
        chk("rst_trap_addr", trap_addr, 32'h0);
        chk("rst_ret_addr", ret_addr, 32'h0);
        chk("rst_mtime", mtime, 64'h0);
        csr_rd(MTVEC);   chk("rst_mtvec", csr_out, 32'h40);
        csr_rd(MSTATUS); chk("rst_mstatus", csr_out, 32'h1800);
        csr_rd(MIE);     chk("rst_mie", csr_out, 32'h0);
        csr_rd(MIP);     chk("rst_mip", csr_out, 32'h0);

        // CSR read/modify/write
        csr_op(3'b001, MSCRATCH, 32'hDEADBEEF, 32'h0); chk("csrrw_old", csr_out, 32'h0);
        csr_op(3'b010, MSCRATCH, 32'h10, 32'h0);       chk("csrrs_old", csr_out, 32'hDEADBEEF);
        csr_rd(MSCRATCH);                              chk("mscratch", csr_out, 32'hDEADBEFF);
        csr_op(3'b110, 12'hF11, 32'h0, 32'h0);
        chk("csrrsi0_ro_notrap", go_trap, 1'b0);
        chk("mvendorid", csr_out, 32'h0);
        csr_rd(12'hF14); chk("mhartid", csr_out, 32'h7);
        csr_op(3'b001, 12'hF11, 32'h0, 32'h0);
        chk("ro_write_trap", go_trap, 1'b1);
        chk("ro_write_taddr", trap_addr, 32'h40);
        cyc();
        csr_rd(MCAUSE); chk("ro_write_cause", csr_out, 32'h2);
        csr_rd(12'h7C0); chk("unimpl_trap", go_trap, 1'b1);
        cyc();

        // External interrupt, vectored, then MRET
        csr_op(3'b001, MTVEC, 32'h103, 32'h0);
        csr_rd(MTVEC); chk("mtvec_mode1x", csr_out, 32'h100);
        csr_op(3'b001, MTVEC, 32'h101, 32'h0);
        csr_op(3'b001, MIE, 32'h800, 32'h0);
        csr_op(3'b110, MSTATUS, 32'h0, 32'h8);
        ext_irq = 1'b1; pc = 32'h500;
        issue(OP_RTYPE, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("mei_trap", go_trap, 1'b1);
        chk("mei_taddr", trap_addr, 32'h12C);
        ext_irq = 1'b0;
        cyc();
        chk("mei_pulse_len", go_trap, 1'b0);
        csr_rd(MCAUSE);  chk("mei_cause", csr_out, 32'h8000000B);
        csr_rd(MSTATUS); chk("mei_mstatus", csr_out, 32'h1880);
        chk("mei_mepc", ret_addr, 32'h500);
        issue(OP_RTYPE, 3'b000, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("mret_pulse", ret_trap, 1'b1);
        chk("mret_addr", ret_addr, 32'h500);
        cyc();
        chk("mret_pulse_len", ret_trap, 1'b0);
        csr_rd(MSTATUS); chk("mret_mstatus", csr_out, 32'h1888);

        // Exceptions and their priority
        pc = 32'h800;
        issue(OP_LOAD, 3'b010, 32'h1002, 1'b1, 1'b0, 1'b0);
        chk("ecall_ld_trap", go_trap, 1'b1);
        chk("ecall_ld_taddr", trap_addr, 32'h100);
        cyc();
        csr_rd(MCAUSE); chk("ecall_cause", csr_out, 32'd11);
        csr_rd(MTVAL);  chk("ecall_mtval", csr_out, 32'h0);
        issue(OP_LOAD, 3'b010, 32'h1002, 1'b0, 1'b0, 1'b0);
        chk("ldmis_trap", go_trap, 1'b1);
        chk("ldmis_taddr", trap_addr, 32'h100);
        cyc();
        csr_rd(MCAUSE); chk("ldmis_cause", csr_out, 32'd4);
        csr_rd(MTVAL);  chk("ldmis_mtval", csr_out, 32'h1002);
        issue(OP_STORE, 3'b001, 32'h2001, 1'b0, 1'b0, 1'b0);
        chk("stmis_trap", go_trap, 1'b1);
        cyc();
        csr_rd(MCAUSE); chk("stmis_cause", csr_out, 32'd6);
        issue(OP_JALR, 3'b000, 32'h3, 1'b0, 1'b1, 1'b0);
        cyc();
        csr_rd(MCAUSE); chk("ebreak_over_mis", csr_out, 32'd3);
        issue(OP_LOAD, 3'b010, 32'h1004, 1'b0, 1'b0, 1'b0);
        chk("aligned_ld_notrap", go_trap, 1'b0);

        // Counters and mcountinhibit
        csr_op(3'b001, MCOUNTINH, 32'h5, 32'h0);
        csr_op(3'b001, MCYCLE, 32'hFFFFFFFF, 32'h0);
        csr_op(3'b001, MINSTRET, 32'h1234, 32'h0);
        minstret_inc = 1'b1;
        repeat (3) cyc();
        minstret_inc = 1'b0;
        csr_rd(MCYCLE);   chk("mcycle_frozen", csr_out, 32'hFFFFFFFF);
        csr_rd(MINSTRET); chk("minstret_frozen", csr_out, 32'h1234);
        csr_rd(MCYCLEH);  chk("mcycleh_before", csr_out, 32'h0);
        csr_op(3'b001, MCOUNTINH, 32'h0, 32'h0);
        cyc();
        csr_rd(MCYCLEH);  chk("mcycleh_carry", csr_out, 32'h1);
        csr_rd(MCYCLE);   chk("mcycle_wrap", csr_out, 32'h1);

        // Fast IRQs, then reset in the middle of a trap pulse
        csr_op(3'b110, MSTATUS, 32'h0, 32'h8);
        csr_op(3'b010, MIE, 32'h50000, 32'h0);
        fast_irq = 4'b0101; pc = 32'h600;
        issue(OP_RTYPE, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("fast_trap", go_trap, 1'b1);
        chk("fast_taddr", trap_addr, 32'h140);
        cyc();
        csr_rd(MCAUSE); chk("fast_cause", csr_out, 32'h80000010);
        issue(OP_RTYPE, 3'b000, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("fast_mret", ret_trap, 1'b1);
        cyc();
        issue(OP_RTYPE, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("fast_retrap", go_trap, 1'b1);
        rst_n = 1'b0;
        cyc();
        chk("rstmid_trap", go_trap, 1'b0);
        chk("rstmid_taddr", trap_addr, 32'h0);
        chk("rstmid_mepc", ret_addr, 32'h0);
        rst_n = 1'b1; fast_irq = '0;
        csr_rd(MSTATUS);  chk("rstmid_mstatus", csr_out, 32'h1800);
        csr_rd(MIE);      chk("rstmid_mie", csr_out, 32'h0);
        csr_rd(MSCRATCH); chk("rstmid_mscratch", csr_out, 32'h0);
        csr_rd(MTVEC);    chk("rstmid_mtvec", csr_out, 32'h40);
        csr_rd(MCAUSE);   chk("rstmid_mcause", csr_out, 32'h0);

        // mtime prescaler, MTIP and timer interrupt
        do_reset();
        mtimecmp_wr = 1'b1; mtimecmp_din = 64'd3;
        cyc();
        mtimecmp_wr = 1'b0;
        csr_op(3'b001, MIE, 32'h80, 32'h0);
        csr_op(3'b110, MSTATUS, 32'h0, 32'h8);
        repeat (8) cyc();
        chk("mtime_c11", mtime, 64'd2);
        pc = 32'h700;
        clear_inputs(); opcode[OP_RTYPE] = 1'b1; stage_en = 1'b1;
        cyc();
        chk("mtime_c12", mtime, 64'd3);
        chk("mti_not_yet", go_trap, 1'b0);
        cyc();
        clear_inputs();
        chk("mti_trap", go_trap, 1'b1);
        chk("mti_taddr", trap_addr, 32'h40);
        cyc();
        csr_rd(MCAUSE); chk("mti_cause", csr_out, 32'h80000007);
        csr_rd(MIP);    chk("mtip_set", csr_out, 32'h80);
        mtimecmp_wr = 1'b1; mtimecmp_din = '1;
        cyc();
        mtimecmp_wr = 1'b0;
        csr_rd(MIP);    chk("mtip_clear", csr_out, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
